// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage stallable delay line with per-stage
// valid flags, flush, selectable tap and occupancy count.
module dff_pipe #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [WIDTH-1:0]           tap_q,
  output logic                       tap_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int TW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Flush only clears the flags; data keeps whatever it held.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (en) begin
      data_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
      end
      valid_d = {valid_q[DEPTH-2:0], d_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = valid_q[DEPTH-1];

  // Out-of-range selects (non-power-of-2 DEPTH) fall through to defaults.
  always_comb begin
    tap_q     = RST_VAL;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        tap_q     = data_q[i];
        tap_valid = valid_q[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(valid_q[i]);
    end
  end

endmodule
